mem_arbiter: RTL and testbench

Arbitrates the single byte-wide, synchronous-read RAM port between instruction fetch (IF) and the MEM stage. Splits each word, half or byte access into per-byte RAM cycles and assembles read data little-endian. Returns one-cycle done pulses, and exports stall requests consumed by the pipeline stall controller. Pipeline-freeze (`rdy` low) is honoured mid-transfer without data loss.

---
 rtl/mem_arbiter_pkg.sv | 40 ++++
 rtl/mem_byte_assemble.sv | 62 ++++++
 rtl/mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the byte-wide RAM arbiter:
//   - address / data / RAM lane widths
//   - arbiter state encoding
//   - mem_len codes (LEN_B / LEN_H / LEN_W; code 2'b11 behaves as LEN_W)
//   - Enable / Disable constants
//   - len_last(): converts a length code into the index of the last byte
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int RAM_W  = 8;
  localparam int LANES  = DATA_W / RAM_W;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_RD  = 2'd1,
    ST_MEM_RD = 2'd2,
    ST_MEM_WR = 2'd3
  } arb_state_e;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  // Index of the final byte of an access (n-1).
  function automatic logic [1:0] len_last(input logic [1:0] len);
    case (len)
      LEN_B:   return 2'd0;
      LEN_H:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_assemble.sv
// -----------------------------------------------------------------------------
// mem_byte_assemble
//   Byte-lane capture register for little-endian read assembly. Each captured
//   RAM byte lands in lane cap_idx. The word output merges the byte being
//   captured this cycle, so the owner can register the complete word on the
//   same edge as the final capture. Lanes above 'last' read as zero.
//
// Ports
//   clk, rst  : clock, synchronous active-high reset
//   rdy       : global ready; no update while low
//   clear     : empty all lanes (start of a transaction)
//   cap_en    : capture din into lane cap_idx on this edge
//   cap_idx   : lane being captured
//   last      : index of the final byte of the access (n-1)
//   din       : RAM read byte
//   word      : assembled, zero-filled word (combinational)
// -----------------------------------------------------------------------------
module mem_byte_assemble
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              cap_en,
  input  logic [1:0]        cap_idx,
  input  logic [1:0]        last,
  input  logic [RAM_W-1:0]  din,
  output logic [DATA_W-1:0] word
);

  logic [LANES-1:0][RAM_W-1:0] lanes;

  // NOTE: this is a small data register, not a RAM, so it gets a reset like
  // any other flop; clearing it keeps stale bytes of a previous access from
  // ever reaching the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      lanes <= '0;
    end else if (rdy) begin
      if (clear) begin
        lanes <= '0;
      end else if (cap_en) begin
        lanes[cap_idx] <= din;
      end
    end
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i <= int'(last)) begin
        if (cap_en && int'(cap_idx) == i) begin
          word[i*RAM_W +: RAM_W] = din;
        end else begin
          word[i*RAM_W +: RAM_W] = lanes[i];
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one byte-wide, synchronous-read RAM port between instruction fetch
//   (IF) and the MEM stage. Word/half/byte accesses are split into per-byte RAM
//   cycles; read bytes are assembled little-endian. Completion is signalled by
//   one-cycle done pulses, and stall requests are exported combinationally.
//   rdy low freezes every register mid-transfer without losing data.
//
//   Build option: define MEMARB_IF_ABORT_EN to let a MEM request abort an
//   in-flight IF read (IF restarts from byte 0 afterwards). Without it, MEM
//   waits for the IF read to complete.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   rdy             : global ready, low = freeze
//   if_req/if_addr  : IF word read request, held until if_done
//   if_done/if_data : completion pulse and fetched word
//   mem_req/mem_we/mem_len/mem_addr/mem_wdata : MEM load/store request
//   mem_done/mem_rdata : completion pulse and zero-extended load data
//   ram_a/ram_wr/ram_dout : RAM address, write enable, write byte (comb.)
//   ram_din         : RAM read byte, valid one cycle after its address
//   stallreq_if/stallreq_mem : req & ~done (comb.)
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [RAM_W-1:0]  ram_dout,
  input  logic [RAM_W-1:0]  ram_din,
  output logic              stallreq_if,
  output logic              stallreq_mem
);

  arb_state_e                  state;
  logic [1:0]                  issue;      // next byte whose address is driven
  logic [1:0]                  capt;       // next byte lane to capture
  logic [1:0]                  last;       // index of final byte (n-1)
  logic                        issued_all; // final address already sampled by RAM
  logic [ADDR_W-1:0]           base;
  logic [LANES-1:0][RAM_W-1:0] wdata;

  logic              rd_state;
  logic              cap_en;
  logic              final_cap;
  logic              start_mem;
  logic              start_if;
  logic [1:0]        ram_off;
  logic [DATA_W-1:0] asm_word;

  assign stallreq_if  = if_req  & ~if_done;
  assign stallreq_mem = mem_req & ~mem_done;

  assign rd_state = (state == ST_IF_RD) || (state == ST_MEM_RD);

  // A byte is pending capture once its address was sampled one edge earlier:
  // either a later byte is already being issued, or the final issue happened.
  assign cap_en    = rd_state && ((issue > capt) || issued_all);
  assign final_cap = cap_en && (capt == last);

  // Acceptance. The done-cycle gap falls out of checking the done registers.
  always_comb begin
    start_mem = DISABLE;
    start_if  = DISABLE;
    if (state == ST_IDLE && !if_done && !mem_done) begin
      start_mem = mem_req;
      start_if  = if_req && !mem_req;
    end
`ifdef MEMARB_IF_ABORT_EN
    // A MEM request preempts an IF read unless that read completes this edge.
    if (state == ST_IF_RD && mem_req && !final_cap) begin
      start_mem = ENABLE;
    end
`endif
  end

  // RAM port. During a read freeze the address of the pending capture is
  // replayed so ram_din is valid again on the first cycle after rdy returns.
  assign ram_off = (rd_state && !rdy) ? capt : issue;

  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    ram_a    = '0;
    ram_wr   = DISABLE;
    ram_dout = '0;
    case (state)
      ST_IF_RD, ST_MEM_RD: begin
        ram_a = base + {{(ADDR_W-2){1'b0}}, ram_off};
      end
      ST_MEM_WR: begin
        ram_a    = base + {{(ADDR_W-2){1'b0}}, issue};
        ram_dout = wdata[issue];
        ram_wr   = rdy;
      end
      default: ;
    endcase
    if (rst) ram_wr = DISABLE;
  end

  mem_byte_assemble u_assemble (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .clear   (start_mem || start_if),
    .cap_en  (cap_en),
    .cap_idx (capt),
    .last    (last),
    .din     (ram_din),
    .word    (asm_word)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      issue      <= '0;
      capt       <= '0;
      last       <= '0;
      issued_all <= DISABLE;
      base       <= '0;
      wdata      <= '0;
      if_done    <= DISABLE;
      mem_done   <= DISABLE;
      if_data    <= '0;
      mem_rdata  <= '0;
    end else if (rdy) begin
      if_done  <= DISABLE;
      mem_done <= DISABLE;
      if (start_mem) begin
        state      <= mem_we ? ST_MEM_WR : ST_MEM_RD;
        base       <= mem_addr;
        last       <= len_last(mem_len);
        wdata      <= mem_wdata;
        issue      <= '0;
        capt       <= '0;
        issued_all <= DISABLE;
      end else if (start_if) begin
        state      <= ST_IF_RD;
        base       <= if_addr;
        last       <= len_last(LEN_W);
        issue      <= '0;
        capt       <= '0;
        issued_all <= DISABLE;
      end else begin
        case (state)
          ST_IF_RD, ST_MEM_RD: begin
            if (issue == last) issued_all <= ENABLE;
            else               issue      <= issue + 2'd1;
            if (cap_en) capt <= capt + 2'd1;
            if (final_cap) begin
              state <= ST_IDLE;
              if (state == ST_IF_RD) begin
                if_data <= asm_word;
                if_done <= ENABLE;
              end else begin
                mem_rdata <= asm_word;
                mem_done  <= ENABLE;
              end
            end
          end
          ST_MEM_WR: begin
            if (issue == last) begin
              state    <= ST_IDLE;
              mem_done <= ENABLE;
            end else begin
              issue <= issue + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a 1 KiB synchronous-read byte RAM model
//   (address bits 9:0). A vector table covers single transactions; hand-written
//   sequences cover arbitration, freeze, reset and the optional IF abort.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        stallreq_if;
  logic        stallreq_mem;

  mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_done      (if_done),
    .if_data      (if_data),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_len      (mem_len),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_done     (mem_done),
    .mem_rdata    (mem_rdata),
    .ram_a        (ram_a),
    .ram_wr       (ram_wr),
    .ram_dout     (ram_dout),
    .ram_din      (ram_din),
    .stallreq_if  (stallreq_if),
    .stallreq_mem (stallreq_mem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model with a write log.
  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0] ram [0:1023];
  wr_t        wlog [$];

  always @(posedge clk) begin
    ram_din <= ram[ram_a[9:0]];
    if (ram_wr) begin
      ram[ram_a[9:0]] <= ram_dout;
      wlog.push_back('{cyc, ram_a, ram_dout});
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  // Issues one transaction at a negedge, waits for its done pulse, drops the
  // request and idles one extra cycle. lat counts cycles from the accept edge.
  task automatic run_txn(input vec_t v, output logic [31:0] data, output int lat,
                         output int c0);
    c0   = cyc;
    lat  = -1;
    data = '0;
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_len = v.len;
      mem_addr = v.addr; mem_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (v.is_mem ? mem_done : if_done) begin
        lat  = cyc - c0 - 1;
        data = v.is_mem ? mem_rdata : if_data;
        break;
      end
    end
    if_req  = 1'b0;
    mem_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] data;
    int          lat, c0, nb, md, id, kd;
    logic        flag;

    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h13; ram[10'h101] = 8'h05;
    ram[10'h3FE] = 8'h11; ram[10'h3FF] = 8'h22;
    ram[10'h000] = 8'h33; ram[10'h001] = 8'h44;
    ram[10'h302] = 8'hA5; ram[10'h303] = 8'h5A;

    //          mem   we    len    addr          wdata         exp_data      lat
    vecs[0]  = '{1'b0, 1'b0, 2'b10, 32'h00000100, 32'h0,        32'h00000513, 5};
    vecs[1]  = '{1'b1, 1'b1, 2'b10, 32'h00000200, 32'hDEADBEEF, 32'h0,        4};
    vecs[2]  = '{1'b1, 1'b0, 2'b10, 32'h00000200, 32'h0,        32'hDEADBEEF, 5};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 32'h00000201, 32'h0,        32'h000000BE, 2};
    vecs[4]  = '{1'b1, 1'b0, 2'b01, 32'h00000202, 32'h0,        32'h0000DEAD, 3};
    vecs[5]  = '{1'b1, 1'b1, 2'b01, 32'h00000210, 32'h1234ABCD, 32'h0,        2};
    vecs[6]  = '{1'b1, 1'b1, 2'b00, 32'h00000213, 32'hFFFFFF77, 32'h0,        1};
    vecs[7]  = '{1'b1, 1'b0, 2'b11, 32'h00000210, 32'h0,        32'h7700ABCD, 5};
    vecs[8]  = '{1'b0, 1'b0, 2'b10, 32'h00000200, 32'h0,        32'hDEADBEEF, 5};
    vecs[9]  = '{1'b1, 1'b0, 2'b10, 32'hFFFFFFFE, 32'h0,        32'h44332211, 5};
    vecs[10] = '{1'b1, 1'b0, 2'b01, 32'hFFFFFFFF, 32'h0,        32'h00003322, 3};

    // Reset state; if_req held high to show stallreq_if follows its input.
    rst = 1'b1; rdy = 1'b1;
    if_req = 1'b1; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_if_done",   32'(if_done), 32'd0);
    check("rst_mem_done",  32'(mem_done), 32'd0);
    check("rst_if_data",   if_data, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_ram_wr",    32'(ram_wr), 32'd0);
    check("rst_ram_a",     ram_a, 32'd0);
    check("rst_ram_dout",  32'(ram_dout), 32'd0);
    check("rst_stall_if",  32'(stallreq_if), 32'd1);
    check("rst_stall_mem", 32'(stallreq_mem), 32'd0);
    if_req = 1'b0;
    rst    = 1'b0;
    @(negedge clk);

    // Vector table.
    for (int i = 0; i < NV; i++) begin
      wlog.delete();
      run_txn(vecs[i], data, lat, c0);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      if (vecs[i].is_mem && vecs[i].we) begin
        nb = (vecs[i].len == 2'b00) ? 1 : (vecs[i].len == 2'b01) ? 2 : 4;
        check($sformatf("v%0d_wr_count", i), wlog.size(), nb);
        for (int b = 0; b < nb && b < wlog.size(); b++) begin
          check($sformatf("v%0d_wr%0d_addr", i, b), wlog[b].a, vecs[i].addr + b);
          check($sformatf("v%0d_wr%0d_data", i, b), 32'(wlog[b].d),
                32'(vecs[i].wdata[8*b +: 8]));
          check($sformatf("v%0d_wr%0d_cycle", i, b), wlog[b].cyc, c0 + 1 + b);
        end
      end else begin
        check($sformatf("v%0d_data", i), data, vecs[i].exp_data);
      end
    end
    check("if_data_hold", if_data, 32'hDEADBEEF);

    // Simultaneous requests: MEM byte load first, IF after the one-cycle gap.
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h203;
    md = -1; id = -1; flag = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (if_done && md < 0) flag = 1'b1;
      if (mem_done) begin
        md = k;
        check("sim_mem_rdata", mem_rdata, 32'h000000DE);
        check("sim_stall_if",  32'(stallreq_if), 32'd1);
        check("sim_stall_mem", 32'(stallreq_mem), 32'd0);
        mem_req = 1'b0;
      end
      if (if_done) begin
        id = k;
        check("sim_if_data", if_data, 32'h00000513);
        if_req = 1'b0;
        break;
      end
    end
    check("sim_if_first", 32'(flag), 32'd0);
    check("sim_mem_cycle", md, 3);
    check("sim_if_cycle", id, 10);
    @(negedge clk);

    // Freeze for 3 cycles after byte 1 of an IF word read is issued.
    if_req = 1'b1; if_addr = 32'h100;
    id = -1; flag = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ram_wr) flag = 1'b1;
      if (k == 3) rdy = 1'b0;
      if (k == 4) check("frz_ram_a", ram_a, 32'h101);
      if (k == 6) rdy = 1'b1;
      if (if_done) begin
        id = k;
        check("frz_if_data", if_data, 32'h00000513);
        if_req = 1'b0;
        break;
      end
    end
    rdy = 1'b1;
    check("frz_done_cycle", id, 9);
    check("frz_ram_wr", 32'(flag), 32'd0);
    @(negedge clk);

    // Reset in the middle of a word store after two bytes are written.
    wlog.delete();
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10;
    mem_addr = 32'h300; mem_wdata = 32'hCAFEF00D;
    flag = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (mem_done) flag = 1'b1;
    end
    rst = 1'b1; mem_req = 1'b0;
    @(negedge clk);
    check("mrst_mem_done",  32'(mem_done), 32'd0);
    check("mrst_ram_wr",    32'(ram_wr), 32'd0);
    check("mrst_ram_a",     ram_a, 32'd0);
    check("mrst_ram_dout",  32'(ram_dout), 32'd0);
    check("mrst_if_data",   if_data, 32'd0);
    check("mrst_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_done) flag = 1'b1;
    end
    check("mrst_no_done",  32'(flag), 32'd0);
    check("mrst_wr_count", wlog.size(), 2);
    check("mrst_ram300",   32'(ram[10'h300]), 32'h0D);
    check("mrst_ram301",   32'(ram[10'h301]), 32'hF0);
    check("mrst_ram302",   32'(ram[10'h302]), 32'hA5);
    check("mrst_ram303",   32'(ram[10'h303]), 32'h5A);

    // MEM request arriving 2 cycles into an IF read.
    if_req = 1'b1; if_addr = 32'h100;
    md = -1; id = -1; kd = 0; flag = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      kd = k;
      if (k == 2) begin
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h203;
      end
      if (if_done) begin
        if (id >= 0) flag = 1'b1;
        id = k;
        check("abt_if_data", if_data, 32'h00000513);
        if_req = 1'b0;
      end
      if (mem_done) begin
        md = k;
        check("abt_mem_rdata", mem_rdata, 32'h000000DE);
        mem_req = 1'b0;
      end
      if (md > 0 && id > 0) break;
    end
    check("abt_single_if_done", 32'(flag), 32'd0);
`ifdef MEMARB_IF_ABORT_EN
    check("abt_mem_cycle", md, 5);
    check("abt_if_cycle",  id, 12);
`else
    check("abt_if_cycle",  id, 6);
    check("abt_mem_cycle", md, 10);
`endif
    check("abt_finished", kd, (id > md) ? id : md);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
